muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit. Handles the MIPS ops that the single-cycle combinational ALU cannot: mult, multu, div, divu, plus the mthi/mtlo register writes.
- The datapath issues an op with a start pulse, stalls on busy, and reads the HI/LO registers (mfhi/mflo) after done.
- Iterative design: shift-add multiply, restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- Iteration count is fixed at WIDTH (internal constant, not a parameter).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the op on op; sampled only in IDLE.
- op  input  2  0=multu, 1=mult, 2=divu, 3=div.
- a_in  input  WIDTH  multiplicand / dividend (rs).
- b_in  input  WIDTH  multiplier / divisor (rt).
- hi_we  input  1  mthi: load hi from a_in.
- lo_we  input  1  mtlo: load lo from a_in.
- busy  output  1  op in progress; the datapath stalls while high.
- done  output  1  one-cycle pulse when hi/lo hold the new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on rising clk.
- Reset values: busy=0, done=0, hi=0, lo=0; FSM goes to IDLE; iteration counter=0.
- Reset mid-operation: aborts the op. No done pulse. hi/lo are cleared to 0, not written with a partial result.

FSM states:
- IDLE:
  - start=1 at edge E0: latch op; latch |a_in| and |b_in| (magnitudes for signed ops, raw values for unsigned); latch result signs; counter=0; go to RUN; busy=1 after E0.
- RUN:
  - One iteration per edge: multiply is shift-add on a 2*WIDTH accumulator; divide is restoring (shift remainder, trial subtract, set quotient bit).
  - counter increments; after the WIDTH-th RUN edge (E0+WIDTH), go to FIX.
- FIX (edge E0+WIDTH+1):
  - Apply sign correction and write hi/lo; done=1; busy=0; go to IDLE.
  - Total latency: done visible in the cycle after edge E0+33 (WIDTH=32). busy is high for exactly 33 cycles.
  - done returns to 0 on the next edge.

Arithmetic rules:
- mult/multu: {hi,lo} = full 2*WIDTH product; mult is the two's-complement signed product.
- div/divu: lo = quotient truncated toward zero; hi = remainder. For div the remainder takes the sign of the dividend.
- Divide by zero (div or divu): lo = all ones, hi = a_in as latched at start (raw, not the magnitude). Not an error; same latency.
- div of most-negative by -1: lo = 0x80000000, hi = 0 (wraps, no trap).
- Operands are latched at start, so a_in/b_in may change during RUN without affecting the result.

Handshake and boundary rules:
- start while busy: ignored, no queuing.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we in IDLE: the register loads a_in at that edge; both may be asserted together.
- start with hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
- start asserted in the same cycle as done (FSM already in IDLE): accepted normally; busy=1 next cycle.
- hi/lo keep their previous values during RUN. They change only in FIX, on mthi/mtlo, or on reset.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once, 33 cycles after start; busy high for 33 cycles.
- mult a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start divu 100/7, then assert start (op=multu) and hi_we at cycle 5, and change a_in at cycle 10 -> result still lo=14, hi=2; the second start and hi_we have no effect; exactly one done.
- Start mult, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done. New start afterwards completes normally.
- In IDLE: hi_we=1 with a_in=0x12345678, then lo_we=1 with a_in=0xCAFEBABE -> hi=0x12345678, lo=0xCAFEBABE. Same cycle start=1 with lo_we=1 -> lo_we is dropped.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// HI/LO are architectural registers, also writable directly via mthi/mtlo while idle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 is_div_q, neg_q, rneg_q, bzero_q;
    logic [WIDTH-1:0]     a_q, b_q, a_raw_q;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic                 busy_q, done_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, mul_add;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic [2*WIDTH:0]     mul_step, div_sh, div_step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;

    always_comb begin
        a_neg    = op[0] & a_in[WIDTH-1];
        b_neg    = op[0] & b_in[WIDTH-1];
        a_mag    = a_neg ? -a_in : a_in;
        b_mag    = b_neg ? -b_in : b_in;
        // Multiply: low half holds the remaining multiplier bits, product grows from the top.
        mul_add  = acc_q[0] ? a_q : '0;
        mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, mul_add};
        mul_step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        // Divide: upper part is the partial remainder, low half shifts dividend out, quotient in.
        div_sh   = {acc_q[2*WIDTH-1:0], 1'b0};
        div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, b_q};
        div_step = (div_sh[2*WIDTH:WIDTH] >= {1'b0, b_q}) ?
                   {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;
        acc_d    = is_div_q ? div_step : mul_step;
        prod     = neg_q  ? -acc_q[2*WIDTH-1:0]     : acc_q[2*WIDTH-1:0];
        quot     = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StRun;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        is_div_q <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        bzero_q  <= (b_in == '0);
                        a_q      <= a_mag;
                        b_q      <= b_mag;
                        a_raw_q  <= a_in;
                        acc_q    <= {{(WIDTH + 1){1'b0}}, (op[1] ? a_mag : b_mag)};
                    end else begin
                        if (hi_we) hi_q <= a_in;
                        if (lo_we) lo_q <= a_in;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_q <= StFix;
                end
                StFix: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod;
                    end else if (bzero_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quot;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, handshake and reset behaviour.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: plain; 1: disturb inputs mid-run; 2: reset at cycle 10; 3: restart on done
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode, output int done_cnt, output int busy_cnt,
                          output int done_at);
        logic [31:0] hi0, lo0;
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == 16 && mode != 2) begin
                check_eq("hold_hi", hi, hi0);
                check_eq("hold_lo", lo, lo0);
            end
            if (mode == 1) begin
                if (n == 5) begin
                    start = 1'b1;
                    op    = 2'd0;
                    hi_we = 1'b1;
                    a_in  = 32'h5555_5555;
                end
                if (n == 6) begin
                    start = 1'b0;
                    hi_we = 1'b0;
                end
                if (n == 10) a_in = 32'hDEAD_BEEF;
            end
            if (mode == 2) begin
                if (n == 10) reset = 1'b1;
                if (n == 11) begin
                    check_eq("rst_busy", 32'(busy), 32'd0);
                    check_eq("rst_hi", hi, 32'd0);
                    check_eq("rst_lo", lo, 32'd0);
                    reset = 1'b0;
                end
            end
            if (mode == 3) begin
                if (done) begin
                    start = 1'b1;
                    op    = 2'd0;
                    a_in  = 32'd6;
                    b_in  = 32'd7;
                end
                if (done_at > 0 && n == done_at + 1) begin
                    check_eq("b2b_busy", 32'(busy), 32'd1);
                    start = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
        int dc, bc, da;
        run_op(o, a, b, 0, dc, bc, da);
        check_eq({tag, "_done_cnt"}, 32'(dc), 32'd1);
        check_eq({tag, "_done_at"}, 32'(da), 32'd34);
        check_eq({tag, "_busy_cycles"}, 32'(bc), 32'd33);
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int dc, bc, da;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a_in  = '0;
        b_in  = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_hi", hi, 32'd0);
        check_eq("reset_lo", lo, 32'd0);
        reset = 1'b0;

        do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult_minmin", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        do_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_negdiv", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        do_op("divu_zero", 2'd2, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        do_op("div_zero", 2'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        do_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Second start, hi_we and operand changes during RUN must all be ignored.
        run_op(2'd2, 32'd100, 32'd7, 1, dc, bc, da);
        check_eq("disturb_done_cnt", 32'(dc), 32'd1);
        check_eq("disturb_done_at", 32'(da), 32'd34);
        check_eq("disturb_hi", hi, 32'd2);
        check_eq("disturb_lo", lo, 32'd14);

        run_op(2'd1, 32'd9, 32'd9, 2, dc, bc, da);
        check_eq("abort_done_cnt", 32'(dc), 32'd0);
        check_eq("abort_busy_cycles", 32'(bc), 32'd10);
        do_op("after_abort", 2'd1, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC);

        // Start in the done cycle is accepted: 6*7 follows 100/7.
        run_op(2'd2, 32'd100, 32'd7, 3, dc, bc, da);
        check_eq("b2b_first_at", 32'(da), 32'd34);
        wait_done("b2b");
        check_eq("b2b_hi", hi, 32'd0);
        check_eq("b2b_lo", lo, 32'd42);

        @(negedge clk);
        hi_we = 1'b1;
        a_in  = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        a_in  = 32'hCAFE_BABE;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mthi", hi, 32'h1234_5678);
        check_eq("mtlo", lo, 32'hCAFE_BABE);

        // start beats a concurrent mtlo.
        op    = 2'd0;
        a_in  = 32'd2;
        b_in  = 32'd3;
        start = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        check_eq("start_wins_busy", 32'(busy), 32'd1);
        check_eq("start_wins_lo", lo, 32'hCAFE_BABE);
        wait_done("start_wins");
        check_eq("start_wins_res_hi", hi, 32'd0);
        check_eq("start_wins_res_lo", lo, 32'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
